// File: rtl/boa_insn_align_pkg.sv
// Shared constants and encoding helpers for the instruction realigner.
package boa_insn_align_pkg;

    localparam logic [31:0] MISA_C = 32'h0000_0004;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM32    = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

endpackage

// File: rtl/boa_insn_decomp.sv
// RVC decompressor: expands one 16-bit encoding into its 32-bit equivalent.
module boa_insn_decomp
    import boa_insn_align_pkg::*;
#(
    parameter bit has_f = 1'b0,
    parameter bit has_d = 1'b0,
    parameter bit has_q = 1'b0
) (
    input  logic [15:0] insn16,
    input  logic        rv64,
    output logic [31:0] insn32,
    output logic        valid
);

    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, lw_imm, ld_imm, lwsp_imm, ldsp_imm, swsp_imm, sdsp_imm;
    logic [20:1] jimm;
    logic [12:1] bimm;
    logic        dq_ok;

    assign c        = insn16;
    assign rd       = c[11:7];
    assign rs2      = c[6:2];
    assign rdp      = {2'b01, c[4:2]};
    assign rs1p     = {2'b01, c[9:7]};
    assign imm6     = {{6{c[12]}}, c[12], c[6:2]};
    assign lw_imm   = {5'b0, c[5], c[12:10], c[6], 2'b0};
    assign ld_imm   = {4'b0, c[6:5], c[12:10], 3'b0};
    assign lwsp_imm = {4'b0, c[3:2], c[12], c[6:4], 2'b0};
    assign ldsp_imm = {3'b0, c[4:2], c[12], c[6:5], 3'b0};
    assign swsp_imm = {4'b0, c[8:7], c[12:9], 2'b0};
    assign sdsp_imm = {3'b0, c[9:7], c[12:10], 3'b0};
    assign jimm     = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    assign bimm     = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
    // Double-width FP loads/stores exist whenever D (or Q, which implies D) is present.
    assign dq_ok    = has_d || has_q;

    // Expand by quadrant and funct3; reserved or unsupported encodings clear valid.
    always_comb begin
        insn32 = 32'h0;
        valid  = 1'b1;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin
                insn32 = enc_i({2'b0, c[10:7], c[12:11], c[5], c[6], 2'b0}, 5'd2, 3'b000, rdp, OP_IMM);
                valid  = |c[12:5];
            end
            5'b00_001: begin insn32 = enc_i(ld_imm, rs1p, 3'b011, rdp, OP_LOAD_FP); valid = dq_ok; end
            5'b00_010: insn32 = enc_i(lw_imm, rs1p, 3'b010, rdp, OP_LOAD);
            5'b00_011: if (rv64) insn32 = enc_i(ld_imm, rs1p, 3'b011, rdp, OP_LOAD);
                       else begin insn32 = enc_i(lw_imm, rs1p, 3'b010, rdp, OP_LOAD_FP); valid = has_f; end
            5'b00_101: begin insn32 = enc_s(ld_imm, rdp, rs1p, 3'b011, OP_STORE_FP); valid = dq_ok; end
            5'b00_110: insn32 = enc_s(lw_imm, rdp, rs1p, 3'b010, OP_STORE);
            5'b00_111: if (rv64) insn32 = enc_s(ld_imm, rdp, rs1p, 3'b011, OP_STORE);
                       else begin insn32 = enc_s(lw_imm, rdp, rs1p, 3'b010, OP_STORE_FP); valid = has_f; end
            5'b01_000: insn32 = enc_i(imm6, rd, 3'b000, rd, OP_IMM);
            5'b01_001: if (rv64) begin insn32 = enc_i(imm6, rd, 3'b000, rd, OP_IMM32); valid = (rd != 5'd0); end
                       else insn32 = enc_j(jimm, 5'd1);
            5'b01_010: insn32 = enc_i(imm6, 5'd0, 3'b000, rd, OP_IMM);
            5'b01_011: begin
                if (rd == 5'd2)
                    insn32 = enc_i({{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0}, 5'd2, 3'b000, 5'd2, OP_IMM);
                else
                    insn32 = {{14{c[12]}}, c[12], c[6:2], rd, OP_LUI};
                valid = |{c[12], c[6:2]};
            end
            5'b01_100: case (c[11:10])
                2'b00: begin insn32 = enc_i({6'b000000, c[12], c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM); valid = rv64 || !c[12]; end
                2'b01: begin insn32 = enc_i({6'b010000, c[12], c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM); valid = rv64 || !c[12]; end
                2'b10: insn32 = enc_i(imm6, rs1p, 3'b111, rs1p, OP_IMM);
                default: case ({c[12], c[6:5]})
                    3'b000: insn32 = enc_r(7'h20, rdp, rs1p, 3'b000, rs1p, OP_OP);
                    3'b001: insn32 = enc_r(7'h00, rdp, rs1p, 3'b100, rs1p, OP_OP);
                    3'b010: insn32 = enc_r(7'h00, rdp, rs1p, 3'b110, rs1p, OP_OP);
                    3'b011: insn32 = enc_r(7'h00, rdp, rs1p, 3'b111, rs1p, OP_OP);
                    3'b100: begin insn32 = enc_r(7'h20, rdp, rs1p, 3'b000, rs1p, OP_OP32); valid = rv64; end
                    3'b101: begin insn32 = enc_r(7'h00, rdp, rs1p, 3'b000, rs1p, OP_OP32); valid = rv64; end
                    default: valid = 1'b0;
                endcase
            endcase
            5'b01_101: insn32 = enc_j(jimm, 5'd0);
            5'b01_110: insn32 = enc_b(bimm, 5'd0, rs1p, 3'b000);
            5'b01_111: insn32 = enc_b(bimm, 5'd0, rs1p, 3'b001);
            5'b10_000: begin insn32 = enc_i({6'b0, c[12], c[6:2]}, rd, 3'b001, rd, OP_IMM); valid = rv64 || !c[12]; end
            5'b10_001: begin insn32 = enc_i(ldsp_imm, 5'd2, 3'b011, rd, OP_LOAD_FP); valid = dq_ok; end
            5'b10_010: begin insn32 = enc_i(lwsp_imm, 5'd2, 3'b010, rd, OP_LOAD); valid = (rd != 5'd0); end
            5'b10_011: if (rv64) begin insn32 = enc_i(ldsp_imm, 5'd2, 3'b011, rd, OP_LOAD); valid = (rd != 5'd0); end
                       else begin insn32 = enc_i(lwsp_imm, 5'd2, 3'b010, rd, OP_LOAD_FP); valid = has_f; end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin insn32 = enc_i(12'h0, rd, 3'b000, 5'd0, OP_JALR); valid = (rd != 5'd0); end
                    else insn32 = enc_r(7'h00, rs2, 5'd0, 3'b000, rd, OP_OP);
                end else if (rs2 == 5'd0)
                    insn32 = (rd == 5'd0) ? INSN_EBREAK : enc_i(12'h0, rd, 3'b000, 5'd1, OP_JALR);
                else
                    insn32 = enc_r(7'h00, rs2, rd, 3'b000, rd, OP_OP);
            end
            5'b10_101: begin insn32 = enc_s(sdsp_imm, rs2, 5'd2, 3'b011, OP_STORE_FP); valid = dq_ok; end
            5'b10_110: insn32 = enc_s(swsp_imm, rs2, 5'd2, 3'b010, OP_STORE);
            5'b10_111: if (rv64) insn32 = enc_s(sdsp_imm, rs2, 5'd2, 3'b011, OP_STORE);
                       else begin insn32 = enc_s(swsp_imm, rs2, 5'd2, 3'b010, OP_STORE_FP); valid = has_f; end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/boa_insn_align.sv
// Instruction realigner: halfword queue between fetch and decode, with RVC expansion.
module boa_insn_align
    import boa_insn_align_pkg::*;
#(
    parameter int hw_depth = 4,
    parameter bit has_f    = 1'b0,
    parameter bit has_d    = 1'b0,
    parameter bit has_q    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rv64,
    input  logic [31:0] misa,
    input  logic        flush,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_data,
    input  logic        f_fault,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_insn,
    output logic [31:0] d_pc,
    output logic        d_comp,
    output logic        d_illegal,
    output logic        d_fault
);

    localparam int PW = $clog2(hw_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(hw_depth);

    logic [15:0]         q_data [hw_depth];
    logic [hw_depth-1:0] q_fault;
    logic [PW-1:0]       rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0]       count, count_after_pop, space, pop_n, push_n;
    logic [31:0]         head_pc;
    logic [15:0]         h0, h1;
    logic                f0, f1;
    logic                is_comp, avail, extract, push, misa_c, ill, flt;
    logic [31:0]         dec_insn;
    logic                dec_valid;

    assign rd_nxt  = rd_ptr + PW'(1);
    assign h0      = q_data[rd_ptr];
    assign h1      = q_data[rd_nxt];
    assign f0      = q_fault[rd_ptr];
    assign f1      = q_fault[rd_nxt];
    assign misa_c  = |(misa & MISA_C);

    // A halfword whose low two bits are not 11 is a complete compressed instruction.
    assign is_comp = (h0[1:0] != 2'b11);
    assign avail   = is_comp ? (count != '0) : (count >= CW'(2));
    assign extract = !flush && avail && (!d_valid || d_ready);
    assign pop_n   = extract ? (is_comp ? CW'(1) : CW'(2)) : '0;

    // Space is judged after this cycle's pop so fetch can refill while decode drains.
    assign count_after_pop = count - pop_n;
    assign space           = DEPTH_C - count_after_pop;
    assign f_ready         = !flush && (space >= CW'(2));
    assign push            = f_valid && f_ready;
    assign push_n          = f_addr[1] ? CW'(1) : CW'(2);

    assign ill = is_comp && (!dec_valid || !misa_c);
    assign flt = is_comp ? f0 : (f0 | f1);

    boa_insn_decomp #(
        .has_f (has_f),
        .has_d (has_d),
        .has_q (has_q)
    ) u_decomp (
        .insn16 (h0),
        .rv64   (rv64),
        .insn32 (dec_insn),
        .valid  (dec_valid)
    );

    // Queue storage: an odd fetch address carries only its upper halfword.
    always_ff @(posedge clk) begin
        if (push) begin
            if (f_addr[1]) begin
                q_data[wr_ptr]  <= f_data[31:16];
                q_fault[wr_ptr] <= f_fault;
            end else begin
                q_data[wr_ptr]                <= f_data[15:0];
                q_data[wr_ptr + PW'(1)]       <= f_data[31:16];
                q_fault[wr_ptr]               <= f_fault;
                q_fault[wr_ptr + PW'(1)]      <= f_fault;
            end
        end
    end

    // Queue pointers, occupancy and the address of the head halfword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            rd_ptr <= rd_ptr + pop_n[PW-1:0];
            if (push)
                wr_ptr <= wr_ptr + push_n[PW-1:0];
            count <= count_after_pop + (push ? push_n : '0);
            if (push && (count_after_pop == '0))
                head_pc <= f_addr & 32'hFFFF_FFFE;
            else if (extract)
                head_pc <= head_pc + (is_comp ? 32'd2 : 32'd4);
        end
    end

    // Registered decode stage; faulting or illegal entries carry the raw head halfword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid   <= 1'b0;
            d_insn    <= '0;
            d_pc      <= '0;
            d_comp    <= 1'b0;
            d_illegal <= 1'b0;
            d_fault   <= 1'b0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (extract) begin
            d_valid   <= 1'b1;
            d_pc      <= head_pc;
            d_comp    <= is_comp;
            d_illegal <= ill;
            d_fault   <= flt;
            if (ill || flt)
                d_insn <= {16'h0, h0};
            else
                d_insn <= is_comp ? dec_insn : {h1, h0};
        end else if (d_ready) begin
            d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_boa_insn_align.sv
// Directed bench for boa_insn_align: realignment, expansion, backpressure, flush, reset.
module tb_boa_insn_align;

    logic        clk = 1'b0;
    logic        rst_n, rv64, flush, f_valid, f_ready, f_fault;
    logic [31:0] misa, f_addr, f_data;
    logic        d_valid, d_ready, d_comp, d_illegal, d_fault;
    logic [31:0] d_insn, d_pc;

    int checks = 0;
    int errors = 0;

    boa_insn_align #(.hw_depth(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rv64      (rv64),
        .misa      (misa),
        .flush     (flush),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_addr    (f_addr),
        .f_data    (f_data),
        .f_fault   (f_fault),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_insn    (d_insn),
        .d_pc      (d_pc),
        .d_comp    (d_comp),
        .d_illegal (d_illegal),
        .d_fault   (d_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic flt);
        int n = 0;
        f_valid = 1'b1; f_addr = a; f_data = d; f_fault = flt;
        #1;
        while (f_ready !== 1'b1 && n < 10) begin tick(); #1; n++; end
        chk("push_ready", 32'(f_ready), 32'd1);
        tick();
        f_valid = 1'b0; f_fault = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ec, input logic eil, input logic ef);
        int n = 0;
        while (d_valid !== 1'b1 && n < 8) begin tick(); n++; end
        chk({tag, "_vld"}, 32'(d_valid), 32'd1);
        chk({tag, "_insn"}, d_insn, ei);
        chk({tag, "_pc"}, d_pc, ep);
        chk({tag, "_flags"}, {29'b0, d_comp, d_illegal, d_fault}, {29'b0, ec, eil, ef});
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rv64 = 1'b0; misa = 32'h0000_0104; flush = 1'b0;
        f_valid = 1'b0; f_addr = '0; f_data = '0; f_fault = 1'b0; d_ready = 1'b0;
        #12;
        chk("rst_vld", 32'(d_valid), 32'd0);
        chk("rst_insn", d_insn, 32'h0);
        chk("rst_pc", d_pc, 32'h0);
        chk("rst_flags", {29'b0, d_comp, d_illegal, d_fault}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_f_ready", 32'(f_ready), 32'd1);
        tick();

        // two c.nop from one word
        push(32'h1000, 32'h0001_0001, 1'b0);
        tick();
        chk("lat_vld", 32'(d_valid), 32'd1);
        collect("cnop0", 32'h0000_0013, 32'h1000, 1'b1, 1'b0, 1'b0);
        collect("cnop1", 32'h0000_0013, 32'h1002, 1'b1, 1'b0, 1'b0);
        tick();
        chk("cnop_empty", 32'(d_valid), 32'd0);

        // 32-bit addi x0,x0,1 straddling the word boundary
        push(32'h2000, 32'h0013_0001, 1'b0);
        push(32'h2004, 32'h0001_0010, 1'b0);
        collect("strad_c", 32'h0000_0013, 32'h2000, 1'b1, 1'b0, 1'b0);
        collect("strad_32", 32'h0010_0013, 32'h2002, 1'b0, 1'b0, 1'b0);
        collect("strad_tail", 32'h0000_0013, 32'h2006, 1'b1, 1'b0, 1'b0);

        // odd entry address, all-zero halfword is illegal
        push(32'h3002, 32'h0000_0000, 1'b0);
        collect("odd_ill", 32'h0000_0000, 32'h3002, 1'b1, 1'b1, 1'b0);

        // compressed encoding while misa.C is clear
        misa = 32'h0000_0100;
        push(32'h7002, 32'h0001_0000, 1'b0);
        collect("misa_ill", 32'h0000_0001, 32'h7002, 1'b1, 1'b1, 1'b0);
        misa = 32'h0000_0104;

        // backpressure: output held, queue fills, fetch stalls
        push(32'h4000, 32'h0001_0001, 1'b0);
        push(32'h4004, 32'h0001_0001, 1'b0);
        f_valid = 1'b1; f_addr = 32'h4008; f_data = 32'h0001_0001;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_f_ready", 32'(f_ready), 32'd0);
            chk("bp_vld", 32'(d_valid), 32'd1);
            chk("bp_pc", d_pc, 32'h4000);
            chk("bp_insn", d_insn, 32'h0000_0013);
            tick();
        end
        f_valid = 1'b0;
        collect("bp0", 32'h0000_0013, 32'h4000, 1'b1, 1'b0, 1'b0);
        collect("bp1", 32'h0000_0013, 32'h4002, 1'b1, 1'b0, 1'b0);
        collect("bp2", 32'h0000_0013, 32'h4004, 1'b1, 1'b0, 1'b0);
        collect("bp3", 32'h0000_0013, 32'h4006, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("bp_nodup", 32'(d_valid), 32'd0);

        // fault on the second half of a 32-bit instruction
        push(32'h5000, 32'h0013_0001, 1'b0);
        push(32'h5004, 32'h0001_0010, 1'b1);
        collect("flt_c", 32'h0000_0013, 32'h5000, 1'b1, 1'b0, 1'b0);
        collect("flt_32", 32'h0000_0013, 32'h5002, 1'b0, 1'b0, 1'b1);
        collect("flt_tail", 32'h0000_0001, 32'h5006, 1'b1, 1'b0, 1'b1);

        // flush with three halfwords queued and an output held
        push(32'h6000, 32'h0001_0001, 1'b0);
        push(32'h6004, 32'h0001_0001, 1'b0);
        chk("fl_pre_vld", 32'(d_valid), 32'd1);
        flush = 1'b1; d_ready = 1'b1;
        f_valid = 1'b1; f_addr = 32'h6008; f_data = 32'h0001_0001;
        #1;
        chk("fl_f_ready", 32'(f_ready), 32'd0);
        tick();
        flush = 1'b0; d_ready = 1'b0; f_valid = 1'b0;
        #1;
        chk("fl_vld", 32'(d_valid), 32'd0);
        tick();
        tick();
        chk("fl_empty", 32'(d_valid), 32'd0);
        push(32'h8000, 32'h0001_0001, 1'b0);
        collect("fl_new0", 32'h0000_0013, 32'h8000, 1'b1, 1'b0, 1'b0);
        collect("fl_new1", 32'h0000_0013, 32'h8002, 1'b1, 1'b0, 1'b0);

        // asynchronous reset with a faulted output held
        push(32'h9000, 32'h0001_0001, 1'b1);
        tick();
        chk("rm_pre_vld", 32'(d_valid), 32'd1);
        chk("rm_pre_pc", d_pc, 32'h9000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_vld", 32'(d_valid), 32'd0);
        chk("rm_insn", d_insn, 32'h0);
        chk("rm_pc", d_pc, 32'h0);
        chk("rm_flags", {29'b0, d_comp, d_illegal, d_fault}, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rm_empty", 32'(d_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
